// File: rtl/panda_risc_v_mem_access_arbiter_if.sv
// Request/response bundle of one memory access port.
// The master drives requests and receives in-order responses.
`timescale 1ns/1ps
interface panda_risc_v_mem_access_arbiter_if;
    logic [31:0] req_addr;
    logic        req_read;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        resp_valid;

    modport master (
        output req_addr, req_read, req_wdata, req_wmask, req_valid,
        input  req_ready, resp_rdata, resp_err, resp_valid
    );

    modport slave (
        input  req_addr, req_read, req_wdata, req_wmask, req_valid,
        output req_ready, resp_rdata, resp_err, resp_valid
    );
endinterface

// File: rtl/panda_risc_v_mem_access_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (m0) and LSU (m1).
// A tag FIFO remembers the owner of each accepted request to route in-order responses.
`timescale 1ns/1ps
module panda_risc_v_mem_access_arbiter #(
    parameter int unsigned simulation_delay = 1,
    parameter int unsigned OUTSTANDING_MAX  = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    panda_risc_v_mem_access_arbiter_if.slave         m0,
    panda_risc_v_mem_access_arbiter_if.slave         m1,
    panda_risc_v_mem_access_arbiter_if.master        s,
    output logic [3:0]                               outstanding_n
);

    localparam int unsigned PtrW = $clog2(OUTSTANDING_MAX);

    logic [3:0]                 count_q, count_d;
    logic [PtrW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OUTSTANDING_MAX-1:0] tag_q, tag_d;
    logic                       last_grant_q, last_grant_d;
    logic                       lock_q, lock_d;
    logic                       lock_id_q, lock_id_d;

    logic tag_full, any_valid, grant, accept, pop, head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(OUTSTANDING_MAX - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        tag_full  = (count_q == 4'(OUTSTANDING_MAX));
        any_valid = m0.req_valid | m1.req_valid;
        // grant: 0 selects m0, 1 selects m1
        if (lock_q) begin
            grant = lock_id_q;
        end else if (m0.req_valid && m1.req_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = m1.req_valid;
        end

        s.req_valid = any_valid & ~tag_full & ~rst;
        s.req_addr  = grant ? m1.req_addr  : m0.req_addr;
        s.req_read  = grant ? m1.req_read  : m0.req_read;
        s.req_wdata = grant ? m1.req_wdata : m0.req_wdata;
        s.req_wmask = grant ? m1.req_wmask : m0.req_wmask;

        m0.req_ready = s.req_valid & s.req_ready & ~grant;
        m1.req_ready = s.req_valid & s.req_ready & grant;

        accept = s.req_valid & s.req_ready;
        // A response with nothing outstanding is dropped rather than corrupting the FIFO
        pop    = s.resp_valid & (count_q != 4'd0) & ~rst;
        head   = tag_q[rptr_q];

        m0.resp_valid = pop & ~head;
        m1.resp_valid = pop & head;
        m0.resp_rdata = s.resp_rdata;
        m1.resp_rdata = s.resp_rdata;
        m0.resp_err   = s.resp_err;
        m1.resp_err   = s.resp_err;

        outstanding_n = count_q;
    end

    always_comb begin
        tag_d        = tag_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;

        if (accept) begin
            tag_d[wptr_q] = grant;
            wptr_d        = ptr_inc(wptr_q);
            last_grant_d  = grant;
            lock_d        = 1'b0;
        end else if (s.req_valid) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end

        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end

        unique case ({accept, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= 4'd0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            tag_q        <= '0;
            last_grant_q <= 1'b1;
            lock_q       <= 1'b0;
            lock_id_q    <= 1'b0;
        end else begin
            count_q      <= count_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            tag_q        <= tag_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(s.resp_valid && (count_q == 4'd0)))
        else $error("response with no request outstanding (sim delay %0d)", simulation_delay);

endmodule

// File: tb/tb_panda_risc_v_mem_access_arbiter.sv
// Bench for the IFU/LSU memory access arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_panda_risc_v_mem_access_arbiter;
    localparam int OM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] outstanding_n;

    panda_risc_v_mem_access_arbiter_if m0_if();
    panda_risc_v_mem_access_arbiter_if m1_if();
    panda_risc_v_mem_access_arbiter_if s_if();

    panda_risc_v_mem_access_arbiter #(
        .simulation_delay(1),
        .OUTSTANDING_MAX (OM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m0           (m0_if),
        .m1           (m1_if),
        .s            (s_if),
        .outstanding_n(outstanding_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owners of in-flight requests in issue order, the last winner and
    // the master whose stalled request must be held until accepted (-1 when none).
    int owners[$];
    int last_g;
    int held;

    always @(negedge clk) begin
        int g;
        bit sv, pop;
        if (rst) begin
            chk("rst_s_valid", {31'd0, s_if.req_valid}, 0);
            chk("rst_m0_ready", {31'd0, m0_if.req_ready}, 0);
            chk("rst_m1_ready", {31'd0, m1_if.req_ready}, 0);
            chk("rst_m0_resp_valid", {31'd0, m0_if.resp_valid}, 0);
            chk("rst_m1_resp_valid", {31'd0, m1_if.resp_valid}, 0);
            chk("rst_outstanding", {28'd0, outstanding_n}, 0);
            owners.delete();
            last_g = 1;
            held   = -1;
        end else begin
            if (held >= 0) g = held;
            else if (m0_if.req_valid && m1_if.req_valid) g = 1 - last_g;
            else g = m1_if.req_valid ? 1 : 0;
            sv = (m0_if.req_valid || m1_if.req_valid) && (owners.size() < OM);
            chk("s_valid", {31'd0, s_if.req_valid}, {31'd0, sv});
            chk("m0_ready", {31'd0, m0_if.req_ready}, {31'd0, sv && s_if.req_ready && g == 0});
            chk("m1_ready", {31'd0, m1_if.req_ready}, {31'd0, sv && s_if.req_ready && g == 1});
            chk("outstanding", {28'd0, outstanding_n}, owners.size());
            if (sv) begin
                chk("s_addr", s_if.req_addr, g ? m1_if.req_addr : m0_if.req_addr);
                chk("s_wdata", s_if.req_wdata, g ? m1_if.req_wdata : m0_if.req_wdata);
                chk("s_read", {31'd0, s_if.req_read}, {31'd0, g ? m1_if.req_read : m0_if.req_read});
                chk("s_wmask", {28'd0, s_if.req_wmask}, {28'd0, g ? m1_if.req_wmask : m0_if.req_wmask});
            end
            pop = s_if.resp_valid && owners.size() > 0;
            chk("m0_resp_valid", {31'd0, m0_if.resp_valid}, {31'd0, pop && owners[0] == 0});
            chk("m1_resp_valid", {31'd0, m1_if.resp_valid}, {31'd0, pop && owners[0] == 1});
            if (pop) begin
                chk("resp_rdata", owners[0] == 1 ? m1_if.resp_rdata : m0_if.resp_rdata,
                    s_if.resp_rdata);
                chk("resp_err", {30'd0, owners[0] == 1 ? m1_if.resp_err : m0_if.resp_err},
                    {30'd0, s_if.resp_err});
                void'(owners.pop_front());
            end
            if (sv && s_if.req_ready) begin
                owners.push_back(g);
                last_g = g;
                held   = -1;
            end else if (sv) begin
                held = g;
            end
        end
    end

    task automatic drive(input logic r, input logic v0, input logic [31:0] a0,
                         input logic v1, input logic [31:0] a1, input logic sr,
                         input logic rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst                = r;
        m0_if.req_valid    = v0;
        m0_if.req_addr     = a0;
        m0_if.req_wdata    = ~a0;
        m0_if.req_read     = 1'b1;
        m0_if.req_wmask    = 4'hf;
        m1_if.req_valid    = v1;
        m1_if.req_addr     = a1;
        m1_if.req_wdata    = a1 + 32'd1;
        m1_if.req_read     = 1'b0;
        m1_if.req_wmask    = 4'h3;
        s_if.req_ready     = sr;
        s_if.resp_valid    = rv;
        s_if.resp_rdata    = rd;
        s_if.resp_err      = rd[1:0];
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        m0_if.req_valid = 1'b1; m0_if.req_addr = 32'h100; m0_if.req_wdata = 0;
        m0_if.req_read = 1'b1; m0_if.req_wmask = 4'hf;
        m1_if.req_valid = 1'b0; m1_if.req_addr = 0; m1_if.req_wdata = 0;
        m1_if.req_read = 1'b0; m1_if.req_wmask = 0;
        s_if.req_ready = 1'b1; s_if.resp_valid = 1'b0; s_if.resp_rdata = 0; s_if.resp_err = 0;

        // Reset: outputs held inactive even with a valid request pending
        @(negedge clk);
        chk("reset_s_valid", {31'd0, s_if.req_valid}, 0);
        chk("reset_m0_ready", {31'd0, m0_if.req_ready}, 0);
        chk("reset_outstanding", {28'd0, outstanding_n}, 0);

        // Contention: M0, M1, M0, M1, then responses routed in the same order
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'h1000, 1, 32'h2000, 1, 0, 0);
            @(negedge clk);
            chk("cont_addr", s_if.req_addr, (i % 2) ? 32'h2000 : 32'h1000);
            chk("cont_m0_ready", {31'd0, m0_if.req_ready}, (i % 2) ? 0 : 1);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 32'hA0 + i);
            @(negedge clk);
            chk("cont_resp_m0", {31'd0, m0_if.resp_valid}, (i % 2) ? 0 : 1);
            chk("cont_resp_m1", {31'd0, m1_if.resp_valid}, (i % 2) ? 1 : 0);
        end

        // M0 only, response two cycles later
        drive(0, 1, 32'h100, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("m0only_addr", s_if.req_addr, 32'h100);
        chk("m0only_ready", {31'd0, m0_if.req_ready}, 1);
        idle();
        @(negedge clk);
        chk("m0only_outstanding", {28'd0, outstanding_n}, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h13);
        @(negedge clk);
        chk("m0only_resp_valid", {31'd0, m0_if.resp_valid}, 1);
        chk("m0only_rdata", m0_if.resp_rdata, 32'h13);
        chk("m0only_m1_resp", {31'd0, m1_if.resp_valid}, 0);
        idle();
        @(negedge clk);
        chk("m0only_drained", {28'd0, outstanding_n}, 0);

        // Back-pressure with M1 granted first (M0 won last)
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h1100, 1, 32'h2100, 0, 0, 0);
            @(negedge clk);
            chk("bp_addr", s_if.req_addr, 32'h2100);
            chk("bp_m0_ready", {31'd0, m0_if.req_ready}, 0);
        end
        drive(0, 1, 32'h1100, 1, 32'h2100, 1, 0, 0);
        @(negedge clk);
        chk("bp_release_addr", s_if.req_addr, 32'h2100);
        chk("bp_release_m1_ready", {31'd0, m1_if.req_ready}, 1);
        drive(0, 1, 32'h1100, 1, 32'h2100, 1, 0, 0);
        @(negedge clk);
        chk("bp_next_addr", s_if.req_addr, 32'h1100);
        chk("bp_next_m0_ready", {31'd0, m0_if.req_ready}, 1);
        idle();
        @(negedge clk);
        chk("bp_outstanding", {28'd0, outstanding_n}, 2);
        drive(0, 0, 0, 0, 0, 0, 1, 32'hB0);
        @(negedge clk);
        chk("bp_resp_first_m1", {31'd0, m1_if.resp_valid}, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 32'hB1);
        @(negedge clk);
        chk("bp_resp_second_m0", {31'd0, m0_if.resp_valid}, 1);

        // Full: no acceptance until the cycle after a response frees a slot
        for (int i = 0; i < 4; i++) drive(0, 1, 32'h3000 + 4 * i, 0, 0, 1, 0, 0);
        drive(0, 1, 32'h3010, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("full_outstanding", {28'd0, outstanding_n}, 4);
        chk("full_s_valid", {31'd0, s_if.req_valid}, 0);
        drive(0, 1, 32'h3010, 0, 0, 1, 1, 32'hC0);
        @(negedge clk);
        chk("full_pop_s_valid", {31'd0, s_if.req_valid}, 0);
        chk("full_pop_m0_ready", {31'd0, m0_if.req_ready}, 0);
        drive(0, 1, 32'h3010, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("full_after_s_valid", {31'd0, s_if.req_valid}, 1);
        chk("full_after_outstanding", {28'd0, outstanding_n}, 3);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 1, 32'hC1 + i);

        // Push and pop together at count 2, crossing the pointer wrap
        drive(0, 1, 32'h4000, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 32'h4100, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 32'hD0);
        @(negedge clk);
        chk("wrap_resp_t0_m0", {31'd0, m0_if.resp_valid}, 1);
        drive(0, 1, 32'h4200, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 32'h4300, 1, 1, 32'hD1);
        @(negedge clk);
        chk("wrap_resp_t1_m1", {31'd0, m1_if.resp_valid}, 1);
        chk("wrap_count_before", {28'd0, outstanding_n}, 2);
        drive(0, 1, 32'h4400, 0, 0, 1, 1, 32'hD2);
        @(negedge clk);
        chk("wrap_resp_t2_m0", {31'd0, m0_if.resp_valid}, 1);
        chk("wrap_count_mid", {28'd0, outstanding_n}, 2);
        drive(0, 0, 0, 0, 0, 0, 1, 32'hD3);
        @(negedge clk);
        chk("wrap_count_after", {28'd0, outstanding_n}, 2);
        chk("wrap_resp_t3_m1", {31'd0, m1_if.resp_valid}, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 32'hD4);
        @(negedge clk);
        chk("wrap_resp_t4_m0", {31'd0, m0_if.resp_valid}, 1);
        chk("wrap_resp_t4_not_m1", {31'd0, m1_if.resp_valid}, 0);

        // Reset with three requests in flight
        for (int i = 0; i < 3; i++) drive(0, 1, 32'h5000 + 4 * i, 0, 0, 1, 0, 0);
        drive(1, 1, 32'h5010, 1, 32'h5020, 1, 0, 0);
        @(negedge clk);
        chk("midrst_outstanding", {28'd0, outstanding_n}, 0);
        chk("midrst_s_valid", {31'd0, s_if.req_valid}, 0);
        chk("midrst_m0_ready", {31'd0, m0_if.req_ready}, 0);
        chk("midrst_m1_ready", {31'd0, m1_if.req_ready}, 0);
        drive(0, 1, 32'h6000, 1, 32'h7000, 1, 0, 0);
        @(negedge clk);
        chk("postrst_addr", s_if.req_addr, 32'h6000);
        chk("postrst_m0_ready", {31'd0, m0_if.req_ready}, 1);
        drive(0, 1, 32'h6000, 1, 32'h7000, 1, 0, 0);
        @(negedge clk);
        chk("postrst_next_addr", s_if.req_addr, 32'h7000);
        idle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
